// File: rtl/vga_sync_decoder.sv
// Recovers pixel_x/pixel_y/video_on from hsync/vsync and verifies the timing.
// Define VGA_DEC_SYNC_FF_EN when the sync source is asynchronous to clk.
module vga_sync_decoder #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       frame_start,
    output logic       locked,
    output logic       sync_err
);
    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int HS_POS  = H_DISPLAY + H_FP;
    localparam int VS_POS  = V_DISPLAY + V_FP;
    localparam int HWD     = 2 * H_TOTAL * CLK_DIV;
    localparam int VWD     = 2 * V_TOTAL;
    localparam int HTW     = $clog2(HWD + 1);
    localparam int VTW     = $clog2(VWD + 1);

    typedef enum logic [1:0] {SEARCH, ALIGN, LOCK} state_t;

    state_t         state;
    logic           hs_in, vs_in;
    logic           hs_prev, vs_prev;
    logic           hs_fall, vs_fall;
    logic [3:0]     clk_cnt, clk_nxt;
    logic [9:0]     h_cnt, h_nxt;
    logic [9:0]     v_cnt, v_nxt;
    logic           c_wrap, h_wrap;
    logic           hs_ok, vs_ok;
    logic           hs_to, vs_to;
    logic [HTW-1:0] htmr;
    logic [VTW-1:0] vtmr;

`ifdef VGA_DEC_SYNC_FF_EN
    logic [1:0] hs_sync, vs_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_sync <= '0;
            vs_sync <= '0;
        end else begin
            hs_sync <= {hs_sync[0], hsync};
            vs_sync <= {vs_sync[0], vsync};
        end
    end

    assign hs_in = hs_sync[1];
    assign vs_in = vs_sync[1];
`else
    assign hs_in = hsync;
    assign vs_in = vsync;
`endif

    assign hs_fall = hs_prev & ~hs_in;
    assign vs_fall = vs_prev & ~vs_in;

    // Checks compare against where the free-running counters land this clk.
    assign c_wrap  = clk_cnt == 4'(CLK_DIV - 1);
    assign h_wrap  = c_wrap && h_cnt == 10'(H_TOTAL - 1);
    assign clk_nxt = c_wrap ? 4'd0 : clk_cnt + 4'd1;

    always_comb begin
        h_nxt = h_cnt;
        v_nxt = v_cnt;
        if (c_wrap)
            h_nxt = (h_cnt == 10'(H_TOTAL - 1)) ? 10'd0 : h_cnt + 10'd1;
        if (h_wrap)
            v_nxt = (v_cnt == 10'(V_TOTAL - 1)) ? 10'd0 : v_cnt + 10'd1;
    end

    assign hs_ok = h_nxt == 10'(HS_POS) && clk_nxt == 4'd0;
    assign vs_ok = v_nxt == 10'(VS_POS) && h_nxt == 10'd0 && clk_nxt == 4'd0;
    assign hs_to = state != SEARCH && !hs_fall && htmr >= HTW'(HWD - 1);
    assign vs_to = state != SEARCH && !vs_fall && h_wrap
                   && vtmr >= VTW'(VWD - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SEARCH;
            hs_prev     <= 1'b0;
            vs_prev     <= 1'b0;
            clk_cnt     <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            htmr        <= '0;
            vtmr        <= '0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            hs_prev  <= hs_in;
            vs_prev  <= vs_in;
            sync_err <= 1'b0;
            clk_cnt  <= clk_nxt;
            h_cnt    <= h_nxt;
            v_cnt    <= v_nxt;
            htmr     <= (state == SEARCH || hs_fall) ? '0 : htmr + HTW'(1);
            if (state == SEARCH || vs_fall)
                vtmr <= '0;
            else if (h_wrap)
                vtmr <= vtmr + VTW'(1);

            // Reloading on a matching edge equals free-running, so load always.
            if (vs_fall) begin
                clk_cnt <= '0;
                h_cnt   <= '0;
                v_cnt   <= 10'(VS_POS);
                if (state == SEARCH) begin
                    state <= ALIGN;
                end else if (vs_ok) begin
                    state <= LOCK;
                end else begin
                    state    <= SEARCH;
                    sync_err <= 1'b1;
                end
            end else if (hs_fall) begin
                clk_cnt <= '0;
                h_cnt   <= 10'(HS_POS);
                if (state != SEARCH && !hs_ok) begin
                    state    <= SEARCH;
                    sync_err <= 1'b1;
                end
            end else if (hs_to || vs_to) begin
                state    <= SEARCH;
                sync_err <= 1'b1;
            end

            pixel_x     <= h_cnt;
            pixel_y     <= v_cnt;
            video_on    <= state == LOCK && h_cnt < 10'(H_DISPLAY)
                           && v_cnt < 10'(V_DISPLAY);
            frame_start <= state == LOCK && h_cnt == 10'd0
                           && v_cnt == 10'd0 && clk_cnt == 4'd0;
            locked      <= state == LOCK;
        end
    end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder using a scaled-down timing set so
// several lock/unlock cycles fit in a short run.
module tb_vga_sync_decoder;
    localparam int CD  = 2;
    localparam int HD  = 8;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int HBP = 3;
    localparam int VD  = 6;
    localparam int VFP = 2;
    localparam int VS  = 1;
    localparam int VBP = 2;
    localparam int HT  = HD + HFP + HS + HBP;
    localparam int VT  = VD + VFP + VS + VBP;
    localparam int FR  = HT * VT * CD;
    localparam int WD  = 2 * HT * CD;
    localparam int FD  = 3;
`ifdef VGA_DEC_SYNC_FF_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int x;
        int y;
        int c;
        bit lk;
        bit err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hsync = 1'b1;
    logic       vsync = 1'b1;
    logic [9:0] pixel_x, pixel_y;
    logic       video_on, frame_start, locked, sync_err;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n = 0;
    int   sc = 0, sh = 0, sv = 0;
    bit   lk = 0, hold = 0, tog = 0;
    int   vs_cnt = 0, last_hsf = 0, fault_v = -1;
    int   err_pulses = 0;

    vga_sync_decoder #(
        .CLK_DIV(CD), .H_DISPLAY(HD), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .frame_start(frame_start), .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge %0d: got %0d expected %0d",
                     name, n, act, exp);
        end
    endtask

    task automatic fault();
        lk = 0;
        vs_cnt = 0;
        if (sb.size() > 0) sb[sb.size() - 1].err = 1'b1;
    endtask

    // One source clock: advance the reference timing generator, drive pins,
    // push what the decoder must show LAT clks later.
    task automatic tick(input logic r);
        exp_t e;
        logic hs_n, vs_n;
        int   pos;
        @(negedge clk);
        n++;
        rst = r;
        if (sc == CD - 1) begin
            sc = 0;
            if (sh == HT - 1) begin
                sh = 0;
                sv = (sv == VT - 1) ? 0 : sv + 1;
            end else begin
                sh++;
            end
        end else begin
            sc++;
        end
        pos  = (sh - (HD + HFP)) * CD + sc;
        hs_n = !(sh >= HD + HFP && sh < HD + HFP + HS);
        vs_n = !(sv >= VD + VFP && sv < VD + VFP + VS);
        if (hold || (sv == fault_v && pos >= 0 && pos < FD)) hs_n = 1'b1;
        if (tog) begin
            hs_n = n[0];
            vs_n = n[1];
        end
        if (r) begin
            if (!vs_n && vsync) begin
                if (vs_cnt == 0) last_hsf = n;
                if (vs_cnt < 2) vs_cnt++;
                if (vs_cnt == 2) lk = 1;
            end else if (!hs_n && hsync) begin
                if (vs_cnt > 0 && !(sh == HD + HFP && sc == 0)) fault();
                last_hsf = n;
            end else if (vs_cnt > 0 && n - last_hsf == WD) begin
                fault();
            end
        end else begin
            lk = 0;
            vs_cnt = 0;
        end
        hsync = hs_n;
        vsync = vs_n;
        e = '{x: sh, y: sv, c: sc, lk: lk, err: 1'b0};
        sb.push_back(e);
    endtask

    task automatic go_to(input int v, input int h);
        int k = 0;
        while (!((v < 0 || sv == v) && sh == h && sc == 0) && k < FR + 2) begin
            tick(1'b1);
            k++;
        end
    endtask

    task automatic run_lock(input string name, input int budget);
        int k = 0;
        while (!lk && k < budget) begin
            tick(1'b1);
            k++;
        end
        repeat (LAT + 1) tick(1'b1);
        chk(name, 32'(locked), 32'd1);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sync_err) err_pulses++;
            if (sb.size() > LAT) begin
                e = sb.pop_front();
                if (rst) begin
                    chk("locked", 32'(locked), 32'(e.lk));
                    chk("sync_err", 32'(sync_err), 32'(e.err));
                    chk("video_on", 32'(video_on),
                        32'(e.lk && e.x < HD && e.y < VD));
                    chk("frame_start", 32'(frame_start),
                        32'(e.lk && e.x == 0 && e.y == 0 && e.c == 0));
                    if (e.lk) begin
                        chk("pixel_x", 32'(pixel_x), e.x);
                        chk("pixel_y", 32'(pixel_y), e.y);
                    end
                end
            end
            if (!rst) begin
                chk("rst_pixel_x", 32'(pixel_x), 32'd0);
                chk("rst_pixel_y", 32'(pixel_y), 32'd0);
                chk("rst_video_on", 32'(video_on), 32'd0);
                chk("rst_frame_start", 32'(frame_start), 32'd0);
                chk("rst_locked", 32'(locked), 32'd0);
                chk("rst_sync_err", 32'(sync_err), 32'd0);
            end
        end
    end

    initial begin
        rst = 1'b0;
        tog = 1;
        repeat (5) tick(1'b0);
        tog = 0;
        sc = CD - 1;
        sh = HT - 1;
        sv = VT - 1;
        tick(1'b1);

        run_lock("first_lock", 3 * FR);
        repeat (FR) tick(1'b1);
        chk("err_count_clean", err_pulses, 0);

        fault_v = (sv + 2) % VT;
        go_to((fault_v + 1) % VT, 0);
        fault_v = -1;
        repeat (4) tick(1'b1);
        chk("unlock_after_late_hs", 32'(locked), 32'd0);
        chk("err_count_late_hs", err_pulses, 1);
        run_lock("relock_after_late_hs", 3 * FR);

        go_to(1, HD + HFP + HS);
        hold = 1;
        repeat (WD + 4) tick(1'b1);
        chk("unlock_hs_watchdog", 32'(locked), 32'd0);
        chk("err_count_watchdog", err_pulses, 2);
        go_to(-1, 0);
        hold = 0;
        run_lock("relock_after_watchdog", 3 * FR);

        go_to(3, 2);
        tick(1'b0);
        #1;
        chk("async_rst_locked", 32'(locked), 32'd0);
        chk("async_rst_pixel_y", 32'(pixel_y), 32'd0);
        chk("async_rst_video_on", 32'(video_on), 32'd0);
        repeat (4) tick(1'b0);
        tick(1'b1);
        run_lock("relock_after_reset", 3 * FR);

        repeat (FR / 2) tick(1'b1);
        chk("err_count_final", err_pulses, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
